// File: rtl/skip_mod_counter.sv
// Runtime-programmable modulo counter with an optional reserved-value window,
// up/down stepping, synchronous load and registered tc / skip_evt / cfg_err flags.
module skip_mod_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] cfg_max,
   input  logic             skip_en,
   input  logic [WIDTH-1:0] skip_lo,
   input  logic [WIDTH-1:0] skip_hi,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             skip_evt,
   output logic             cfg_err
);

   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
   localparam logic [WIDTH:0]   ONE_W = (WIDTH+1)'(1);

   logic             win_ok;
   logic             skip_act;
   logic             cnt_in_win;
   logic             load_in_win;
   logic [WIDTH:0]   cnt_inc;
   logic [WIDTH:0]   cnt_dec;
   logic [WIDTH-1:0] above_win;
   logic [WIDTH-1:0] below_win;
   logic [WIDTH-1:0] count_nxt;
   logic             tc_nxt;
   logic             evt_nxt;

   assign win_ok      = (skip_lo != '0) && (skip_lo <= skip_hi) && (skip_hi < cfg_max);
   assign skip_act    = skip_en & win_ok;
   assign cnt_in_win  = skip_act && (count >= skip_lo) && (count <= skip_hi);
   assign load_in_win = skip_act && (load_val >= skip_lo) && (load_val <= skip_hi);

   // One extra bit keeps +1 / -1 from wrapping silently at the code-space edges.
   assign cnt_inc = {1'b0, count} + ONE_W;
   assign cnt_dec = {1'b0, count} - ONE_W;

   // Only consumed when the window is valid, so hi+1 <= cfg_max and lo-1 >= 0.
   assign above_win = skip_hi + ONE;
   assign below_win = skip_lo - ONE;

   always_comb begin
      count_nxt = count;
      tc_nxt    = 1'b0;
      evt_nxt   = 1'b0;
      if (load) begin
         if (load_val > cfg_max) begin
            count_nxt = cfg_max;
         end else if (load_in_win) begin
            count_nxt = above_win;
         end else begin
            count_nxt = load_val;
         end
      end else if (en) begin
         if (up) begin
            if (count >= cfg_max) begin
               count_nxt = '0;
               tc_nxt    = 1'b1;
            end else if (cnt_in_win || (skip_act && (cnt_inc == {1'b0, skip_lo}))) begin
               count_nxt = above_win;
               evt_nxt   = 1'b1;
            end else begin
               count_nxt = cnt_inc[WIDTH-1:0];
            end
         end else begin
            if (count > cfg_max) begin
               count_nxt = cfg_max;
            end else if (count == '0) begin
               count_nxt = cfg_max;
               tc_nxt    = 1'b1;
            end else if (cnt_in_win || (skip_act && (cnt_dec == {1'b0, skip_hi}))) begin
               count_nxt = below_win;
               evt_nxt   = 1'b1;
            end else begin
               count_nxt = cnt_dec[WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= '0;
         tc       <= 1'b0;
         skip_evt <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         count    <= count_nxt;
         tc       <= tc_nxt;
         skip_evt <= evt_nxt;
         cfg_err  <= skip_en & ~win_ok;
      end
   end

endmodule

// File: tb/tb_skip_mod_counter.sv
// Bench for skip_mod_counter: directed scenarios plus a randomized run, all
// checked against a value-level reference model of the counting rules.
module tb_skip_mod_counter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, up, load, skip_en;
   logic [3:0] load_val, cfg_max, skip_lo, skip_hi;
   logic [3:0] count;
   logic       tc, skip_evt, cfg_err;

   logic [3:0] m_count;
   logic       m_tc, m_evt, m_err;

   int n_vec = 0;
   int n_err = 0;

   skip_mod_counter #(.WIDTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .cfg_max  (cfg_max),
      .skip_en  (skip_en),
      .skip_lo  (skip_lo),
      .skip_hi  (skip_hi),
      .count    (count),
      .tc       (tc),
      .skip_evt (skip_evt),
      .cfg_err  (cfg_err)
   );

   always #5 clk = ~clk;

   function automatic bit in_w(int v, int lo, int hi);
      return (v >= lo) && (v <= hi);
   endfunction

   task automatic model_reset();
      m_count = '0;
      m_tc    = 1'b0;
      m_evt   = 1'b0;
      m_err   = 1'b0;
   endtask

   // Value-level model: legal set is 0..max minus [lo..hi] when the window is active.
   task automatic model_edge();
      int mx, lo, hi, c, lv;
      bit ok, act;
      mx = int'(cfg_max); lo = int'(skip_lo); hi = int'(skip_hi);
      c  = int'(m_count); lv = int'(load_val);
      ok  = (lo > 0) && (lo <= hi) && (hi < mx);
      act = skip_en && ok;
      m_tc  = 1'b0;
      m_evt = 1'b0;
      if (load) begin
         if (lv > mx) c = mx;
         else if (act && in_w(lv, lo, hi)) c = hi + 1;
         else c = lv;
      end else if (en) begin
         if (up) begin
            if (c >= mx) begin
               c = 0; m_tc = 1'b1;
            end else if (act && (in_w(c, lo, hi) || in_w(c + 1, lo, hi))) begin
               c = hi + 1; m_evt = 1'b1;
            end else begin
               c = c + 1;
            end
         end else begin
            if (c > mx) begin
               c = mx;
            end else if (c == 0) begin
               c = mx; m_tc = 1'b1;
            end else if (act && (in_w(c, lo, hi) || in_w(c - 1, lo, hi))) begin
               c = lo - 1; m_evt = 1'b1;
            end else begin
               c = c - 1;
            end
         end
      end
      m_count = 4'(c);
      m_err   = skip_en && !ok;
   endtask

   task automatic check(input string tag);
      n_vec++;
      assert (count === m_count) else begin
         n_err++; $error("FAIL %s count: got %0d, expected %0d", tag, count, m_count);
      end
      n_vec++;
      assert (tc === m_tc) else begin
         n_err++; $error("FAIL %s tc: got %0b, expected %0b", tag, tc, m_tc);
      end
      n_vec++;
      assert (skip_evt === m_evt) else begin
         n_err++; $error("FAIL %s skip_evt: got %0b, expected %0b", tag, skip_evt, m_evt);
      end
      n_vec++;
      assert (cfg_err === m_err) else begin
         n_err++; $error("FAIL %s cfg_err: got %0b, expected %0b", tag, cfg_err, m_err);
      end
   endtask

   task automatic lit(input string tag, input int got, input int exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++; $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check(tag);
   endtask

   task automatic set_cfg(input int mx, input int lo, input int hi, input bit se);
      cfg_max = 4'(mx); skip_lo = 4'(lo); skip_hi = 4'(hi); skip_en = se;
   endtask

   int up_seq[12] = '{1, 2, 3, 4, 5, 6, 9, 10, 11, 12, 13, 0};
   int dn_seq[13] = '{13, 12, 11, 10, 9, 6, 5, 4, 3, 2, 1, 0, 13};

   initial begin
      rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
      set_cfg(13, 7, 8, 1'b1);
      model_reset();
      #3;
      check("reset");
      @(posedge clk); @(posedge clk); #1;
      check("reset_held");
      rst_n = 1'b1;

      en = 1'b1; up = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick("up_run");
         lit("up_seq", int'(count), up_seq[i]);
         if (i == 6)  lit("up_skip_evt", int'(skip_evt), 1);
         if (i == 11) lit("up_tc", int'(tc), 1);
      end

      up = 1'b0;
      for (int i = 0; i < 13; i++) begin
         tick("down_run");
         lit("dn_seq", int'(count), dn_seq[i]);
         if (i == 0) lit("dn_tc", int'(tc), 1);
         if (i == 5) lit("dn_skip_evt", int'(skip_evt), 1);
      end

      en = 1'b0; load = 1'b1; load_val = 4'd8;
      tick("load_in_win");
      lit("load_8", int'(count), 9);
      load_val = 4'd15;
      tick("load_over");
      lit("load_15", int'(count), 13);
      en = 1'b1; up = 1'b1; load_val = 4'd3;
      tick("load_with_en");
      lit("load_en_cnt", int'(count), 3);
      lit("load_en_tc", int'(tc), 0);

      set_cfg(13, 9, 5, 1'b1);
      load_val = 4'd0;
      tick("bad_win_load");
      lit("cfg_err", int'(cfg_err), 1);
      load = 1'b0;
      for (int i = 0; i < 14; i++) begin
         tick("bad_win_run");
         lit("bad_win_seq", int'(count), (i + 1) % 14);
      end

      set_cfg(13, 7, 8, 1'b1);
      en = 1'b0; load = 1'b1; load_val = 4'd12;
      tick("shrink_load");
      load = 1'b0; en = 1'b1; up = 1'b1; cfg_max = 4'd10;
      tick("shrink_up");
      lit("shrink_up_cnt", int'(count), 0);
      lit("shrink_up_tc", int'(tc), 1);
      cfg_max = 4'd13; en = 1'b0; load = 1'b1;
      tick("shrink_reload");
      load = 1'b0; en = 1'b1; up = 1'b0; cfg_max = 4'd10;
      tick("shrink_down");
      lit("shrink_dn_cnt", int'(count), 10);

      cfg_max = 4'd13; en = 1'b0; load = 1'b1; load_val = 4'd10;
      tick("pre_rst_load");
      load = 1'b0; en = 1'b1; up = 1'b1;
      tick("pre_rst_step");
      lit("pre_rst_cnt", int'(count), 11);
      en = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check("mid_reset");
      #2 rst_n = 1'b1; en = 1'b1;
      tick("post_rst");
      lit("post_rst_cnt", int'(count), 1);

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            cfg_max = 4'($urandom_range(0, 15));
            skip_lo = 4'($urandom_range(0, 15));
            skip_hi = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(int'(skip_lo), 15));
            skip_en = 1'($urandom_range(0, 1));
         end
         en       = ($urandom_range(0, 3) != 0);
         up       = 1'($urandom_range(0, 1));
         load     = ($urandom_range(0, 9) == 0);
         load_val = 4'($urandom_range(0, 15));
         tick("random");
         if ($urandom_range(0, 49) == 0) begin
            #2 rst_n = 1'b0;
            #1;
            model_reset();
            check("random_reset");
            #1 rst_n = 1'b1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/skip_mod_counter.md
# skip_mod_counter

Parametrised, runtime-programmable modulo counter with an optional skipped value window, up/down direction, synchronous load and registered event flags. It is the general-purpose successor to the fixed mod-N skip counters: modulus, skip window and direction are inputs, not constants. It sits wherever a sequence index with reserved codes is needed, such as slot and phase generators or timer prescalers.

## Interface
- WIDTH, 4: counter width in bits; all value ports are WIDTH wide.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  advance one step this cycle.
- up  input  1  1 = count up, 0 = count down; sampled only when stepping.
- load  input  1  synchronous load of load_val; has priority over en.
- load_val  input  WIDTH  value to load.
- cfg_max  input  WIDTH  terminal value; the counter spans 0..cfg_max.
- skip_en  input  1  enable the skip window.
- skip_lo  input  WIDTH  first skipped value, inclusive.
- skip_hi  input  WIDTH  last skipped value, inclusive.
- count  output  WIDTH  current count, registered.
- tc  output  1  registered pulse, high for the one cycle in which count shows a wrapped value.
- skip_evt  output  1  registered pulse, high for the one cycle after a step jumped over the window.
- cfg_err  output  1  registered; high while skip_en=1 and the window is invalid.

## Operation
- **Window validity:** the window is valid when 0 < skip_lo <= skip_hi < cfg_max. skip_act = skip_en & valid. An invalid window is ignored (no skipping), and cfg_err=1 from the next edge.
- **Legal set:** {0..cfg_max}, minus [skip_lo..skip_hi] when skip_act=1.
- **Priority each edge:** load > en > hold.
- **Up step, first matching rule wins:**
  - count >= cfg_max -> next count 0, tc=1.
  - skip_act and count in window (after a config change) -> skip_hi+1, skip_evt=1.
  - skip_act and count+1 == skip_lo -> skip_hi+1, skip_evt=1.
  - otherwise count+1.
- **Down step, first matching rule wins:**
  - count > cfg_max -> cfg_max.
  - count == 0 -> cfg_max, tc=1.
  - skip_act and count in window -> skip_lo-1, skip_evt=1.
  - skip_act and count-1 == skip_hi -> skip_lo-1, skip_evt=1.
  - otherwise count-1.
- **Load:**
  - load_val > cfg_max -> count = cfg_max.
  - else if skip_act and load_val is in the window -> skip_hi+1.
  - else load_val.
  - A load never asserts tc or skip_evt.
- **Arithmetic:** all comparisons are unsigned. ±1 is computed in WIDTH+1 bits, so there is no implicit modulo-2^WIDTH wrap. cfg_max = 2^WIDTH-1 is legal. cfg_max = 0 holds count at 0 and pulses tc on every enabled step.
- **Config changes:** cfg_* may change on any cycle. They take effect at the next edge with no pipeline, and the rules above return count to the legal set on the first step or load.
- **Hold:** with en=0 and load=0, count holds, tc=0, skip_evt=0.

## Timing
- **Reset (rst_n low, asynchronous):** count=0, tc=0, skip_evt=0, cfg_err=0. Outputs stay at these values while rst_n is low.
- **Reset release:** synchronous to clk. The first step can occur at the first rising edge with rst_n high.
- **Step latency:** one cycle. en sampled at edge k updates count, tc and skip_evt at edge k.
- **Event pulses:** tc and skip_evt are single-cycle pulses. They are repeated on consecutive cycles if steps repeat.
- **cfg_err:** updated every edge from the current cfg_*, independent of en.
- **Mid-sequence reset:** asserting rst_n mid-sequence clears count immediately, without waiting for a clock edge. Any pending pulse is dropped.
- **Load with en in the same cycle:** the load wins and the step is discarded.

## Test plan
- WIDTH=4, cfg_max=13, skip 7..8, up, en=1 continuously:
  - count runs 0..6, 9..13, 0.
  - skip_evt is high while count=9.
  - tc is high while count=0 after 13.
- Same config, up=0, starting from 0:
  - count runs 13, 12, 11, 10, 9, 6, 5, ... 0, 13.
  - tc is high on 13.
  - skip_evt is high on 6.
- Load with skip 7..8, cfg_max=13:
  - load_val=8 -> count 9.
  - load_val=15 -> count 13.
  - load=1 with en=1 and load_val=3 -> count 3, tc=0.
- Invalid window: skip_lo=9, skip_hi=5, skip_en=1, cfg_max=13.
  - cfg_err=1.
  - count steps through every value 0..13.
- Shrinking the modulus: at count=12, change cfg_max to 10.
  - Up step -> count 0, tc=1.
  - Down step instead -> count 10.
- Reset mid-count: drop rst_n at count=11, between clock edges.
  - count=0 immediately, and tc, skip_evt, cfg_err are all 0.
  - After release, the first en edge gives count=1.
